// File: rtl/spi_slave.sv
// SPI mode-0 slave front-end: synchronises the SPI pins into clk_i, receives
// 8-bit MSB-first frames with a one-cycle strobe and shifts a transmit byte out on MISO.
module spi_slave #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       spi_sclk_i,
    input  logic       spi_mosi_i,
    input  logic       spi_cs_n_i,
    input  logic [7:0] spi_byte_data_i,
    output logic       spi_miso_o,
    output logic       spi_byte_vld_o,
    output logic [7:0] spi_byte_data_o
);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] live;
    logic                   sclk_prev;
    logic                   cs_prev;
    logic                   armed;
    logic [2:0]             bit_cnt;
    logic [7:0]             rx_shift;
    logic [7:0]             tx_shift;

    logic       sclk_s;
    logic       mosi_s;
    logic       cs_s;
    logic       frame_active;
    logic       cs_fall;
    logic       sclk_rise;
    logic       sclk_fall;
    logic [7:0] rx_next;

    // A frame only counts once cs_n has been seen high through a fully refilled
    // synchroniser, so a reset inside a frame waits for a fresh CS assertion.
    always_comb begin
        sclk_s       = sclk_sync[SYNC_STAGES-1];
        mosi_s       = mosi_sync[SYNC_STAGES-1];
        cs_s         = cs_sync[SYNC_STAGES-1];
        frame_active = armed & ~cs_s;
        cs_fall      = armed & cs_prev & ~cs_s;
        sclk_rise    = sclk_s & ~sclk_prev;
        sclk_fall    = ~sclk_s & sclk_prev;
        rx_next      = {rx_shift[6:0], mosi_s};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_sync       <= '0;
            mosi_sync       <= '0;
            cs_sync         <= '1;
            live            <= '0;
            sclk_prev       <= 1'b0;
            cs_prev         <= 1'b1;
            armed           <= 1'b0;
            bit_cnt         <= '0;
            rx_shift        <= '0;
            tx_shift        <= '0;
            spi_miso_o      <= 1'b0;
            spi_byte_vld_o  <= 1'b0;
            spi_byte_data_o <= '0;
        end else begin
            sclk_sync      <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk_i};
            mosi_sync      <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
            cs_sync        <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n_i};
            live           <= {live[SYNC_STAGES-2:0], 1'b1};
            sclk_prev      <= sclk_s;
            cs_prev        <= cs_s;
            spi_byte_vld_o <= 1'b0;

            if (live[SYNC_STAGES-1] && cs_s) begin
                armed <= 1'b1;
            end

            if (!frame_active) begin
                bit_cnt    <= '0;
                spi_miso_o <= 1'b0;
            end else if (cs_fall) begin
                bit_cnt    <= '0;
                tx_shift   <= spi_byte_data_i;
                spi_miso_o <= spi_byte_data_i[7];
            end else begin
                if (sclk_rise) begin
                    rx_shift <= rx_next;
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        spi_byte_data_o <= rx_next;
                        spi_byte_vld_o  <= 1'b1;
                    end
                end
                if (sclk_fall) begin
                    // counter==0 on a fall means a byte just completed: reload
                    if (bit_cnt == 3'd0) begin
                        tx_shift   <= spi_byte_data_i;
                        spi_miso_o <= spi_byte_data_i[7];
                    end else begin
                        tx_shift   <= {tx_shift[6:0], 1'b0};
                        spi_miso_o <= tx_shift[6];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: host-side SPI model with a scoreboard of
// expected received bytes popped on each strobe.
`timescale 1ns/1ps
module tb_spi_slave;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       spi_sclk_i = 1'b0;
    logic       spi_mosi_i = 1'b0;
    logic       spi_cs_n_i = 1'b1;
    logic [7:0] spi_byte_data_i = 8'h7E;
    logic       spi_miso_o;
    logic       spi_byte_vld_o;
    logic [7:0] spi_byte_data_o;

    int         total = 0;
    int         bad = 0;
    int         pulses = 0;
    logic       prev_vld = 1'b0;
    logic [7:0] exp_rx[$];

    spi_slave #(.SYNC_STAGES(2)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .spi_sclk_i      (spi_sclk_i),
        .spi_mosi_i      (spi_mosi_i),
        .spi_cs_n_i      (spi_cs_n_i),
        .spi_byte_data_i (spi_byte_data_i),
        .spi_miso_o      (spi_miso_o),
        .spi_byte_vld_o  (spi_byte_vld_o),
        .spi_byte_data_o (spi_byte_data_o)
    );

    always #2.5 clk_i = ~clk_i;

    // strobe monitor: pops the scoreboard and bumps the transmit byte
    always @(negedge clk_i) begin
        if (!rst_i && spi_byte_vld_o) begin
            logic [7:0] want;
            pulses = pulses + 1;
            total = total + 1;
            if (prev_vld !== 1'b0) begin
                bad = bad + 1;
                $display("FAIL strobe_width: vld high two cycles, got prev=%b want 0", prev_vld);
            end
            total = total + 1;
            if (exp_rx.size() == 0) begin
                bad = bad + 1;
                $display("FAIL rx_unexpected: strobe with data=%02h, no byte expected", spi_byte_data_o);
            end else begin
                want = exp_rx.pop_front();
                if (spi_byte_data_o !== want) begin
                    bad = bad + 1;
                    $display("FAIL rx_data: got %02h want %02h", spi_byte_data_o, want);
                end
            end
            spi_byte_data_i = spi_byte_data_i + 8'd1;
        end
        prev_vld = spi_byte_vld_o;
    end

    task automatic spi_bits(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            spi_mosi_i = v[7-i];
            #24 spi_sclk_i = 1'b1;
            #24 spi_sclk_i = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, input bit chk, input logic [7:0] exp_miso);
        logic [7:0] got;
        got = '0;
        exp_rx.push_back(tx);
        for (int i = 0; i < 8; i++) begin
            spi_mosi_i = tx[7-i];
            #24 spi_sclk_i = 1'b1;
            got = {got[6:0], spi_miso_o};
            #24 spi_sclk_i = 1'b0;
        end
        if (chk) begin
            total = total + 1;
            if (got !== exp_miso) begin
                bad = bad + 1;
                $display("FAIL miso_byte: got %02h want %02h", got, exp_miso);
            end
        end
    endtask

    task automatic cs_assert();
        spi_cs_n_i = 1'b0;
        #30;
    endtask

    task automatic cs_release();
        #24 spi_cs_n_i = 1'b1;
        #60;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (4) @(negedge clk_i);
        total = total + 3;
        if (spi_miso_o !== 1'b0) begin
            bad = bad + 1; $display("FAIL reset_miso: got %b want 0", spi_miso_o);
        end
        if (spi_byte_vld_o !== 1'b0) begin
            bad = bad + 1; $display("FAIL reset_vld: got %b want 0", spi_byte_vld_o);
        end
        if (spi_byte_data_o !== 8'h00) begin
            bad = bad + 1; $display("FAIL reset_data: got %02h want 00", spi_byte_data_o);
        end
        rst_i = 1'b0;
        repeat (4) @(negedge clk_i);
    endtask

    task automatic test_back_to_back();
        int base;
        base = pulses;
        cs_assert();
        spi_byte(8'h2A, 1'b1, 8'h7E);
        spi_byte(8'h2B, 1'b1, 8'h7F);
        #20;
        total = total + 2;
        if (pulses - base !== 2) begin
            bad = bad + 1; $display("FAIL two_bytes_pulses: got %0d want 2", pulses - base);
        end
        if (spi_byte_data_o !== 8'h2B) begin
            bad = bad + 1; $display("FAIL two_bytes_data: got %02h want 2B", spi_byte_data_o);
        end
        spi_byte(8'h00, 1'b1, 8'h80);
        spi_byte(8'h00, 1'b1, 8'h81);
        spi_byte(8'h00, 1'b1, 8'h82);
        cs_release();
        total = total + 3;
        if (pulses - base !== 5) begin
            bad = bad + 1; $display("FAIL five_bytes_pulses: got %0d want 5", pulses - base);
        end
        if (spi_byte_data_o !== 8'h00) begin
            bad = bad + 1; $display("FAIL five_bytes_data: got %02h want 00", spi_byte_data_o);
        end
        if (spi_miso_o !== 1'b0) begin
            bad = bad + 1; $display("FAIL miso_idle: got %b want 0", spi_miso_o);
        end
    endtask

    task automatic test_abort();
        int base;
        base = pulses;
        cs_assert();
        spi_bits(8'hFF, 5);
        cs_release();
        total = total + 1;
        if (pulses !== base) begin
            bad = bad + 1; $display("FAIL abort_no_strobe: got %0d pulses want 0", pulses - base);
        end
        cs_assert();
        spi_byte(8'hA5, 1'b0, 8'h00);
        cs_release();
        total = total + 2;
        if (pulses - base !== 1) begin
            bad = bad + 1; $display("FAIL abort_next: got %0d pulses want 1", pulses - base);
        end
        if (spi_byte_data_o !== 8'hA5) begin
            bad = bad + 1; $display("FAIL abort_data: got %02h want A5", spi_byte_data_o);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        cs_assert();
        spi_bits(8'hC3, 3);
        @(negedge clk_i) rst_i = 1'b1;
        @(negedge clk_i) rst_i = 1'b0;
        total = total + 3;
        if (spi_miso_o !== 1'b0) begin
            bad = bad + 1; $display("FAIL midrst_miso: got %b want 0", spi_miso_o);
        end
        if (spi_byte_vld_o !== 1'b0) begin
            bad = bad + 1; $display("FAIL midrst_vld: got %b want 0", spi_byte_vld_o);
        end
        if (spi_byte_data_o !== 8'h00) begin
            bad = bad + 1; $display("FAIL midrst_data: got %02h want 00", spi_byte_data_o);
        end
        base = pulses;
        spi_bits(8'h00, 5);
        cs_release();
        cs_assert();
        spi_byte(8'h3C, 1'b0, 8'h00);
        cs_release();
        total = total + 2;
        if (pulses - base !== 1) begin
            bad = bad + 1; $display("FAIL midrst_pulses: got %0d want 1", pulses - base);
        end
        if (spi_byte_data_o !== 8'h3C) begin
            bad = bad + 1; $display("FAIL midrst_frame: got %02h want 3C", spi_byte_data_o);
        end
    endtask

    task automatic test_cs_high_sclk();
        int base;
        int miso_bad;
        base = pulses;
        miso_bad = 0;
        for (int i = 0; i < 16; i++) begin
            spi_mosi_i = i[0];
            #24 spi_sclk_i = 1'b1;
            if (spi_miso_o !== 1'b0) miso_bad = miso_bad + 1;
            #24 spi_sclk_i = 1'b0;
        end
        #60;
        total = total + 3;
        if (pulses !== base) begin
            bad = bad + 1; $display("FAIL idle_strobe: got %0d pulses want 0", pulses - base);
        end
        if (miso_bad !== 0) begin
            bad = bad + 1; $display("FAIL idle_miso: got %0d high samples want 0", miso_bad);
        end
        if (spi_byte_data_o !== 8'h3C) begin
            bad = bad + 1; $display("FAIL idle_data: got %02h want 3C", spi_byte_data_o);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_cs_high_sclk();
        total = total + 1;
        if (exp_rx.size() !== 0) begin
            bad = bad + 1; $display("FAIL scoreboard_drain: got %0d left want 0", exp_rx.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
